// File: rtl/pulse_width_detect_mc.sv
// rtl/pulse_width_detect_mc.sv - multi-channel windowed pulse-width detector with accept/reject strobes
// Define PULSE_DET_CNT_EN to add per-channel saturating accepted-pulse counters (cnt_clr, evt_cnt).
module pulse_width_detect_mc #(
    parameter int CH       = 4,
    parameter int MIN_W    = 1,
    parameter int MAX_W    = 1,
    parameter int POLARITY = 1,
    parameter int WCNT_W   = $clog2(MAX_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CH-1:0]        data_in,
    output logic [CH-1:0]        pulse_out,
    output logic [CH*WCNT_W-1:0] pulse_width,
    output logic [CH-1:0]        reject
`ifdef PULSE_DET_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [CH*8-1:0]      evt_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_ACTIVE  = 2'd2,
        S_TOOLONG = 2'd3
    } state_t;

    localparam logic [WCNT_W-1:0] MIN_C = WCNT_W'(MIN_W);
    localparam logic [WCNT_W-1:0] MAX_C = WCNT_W'(MAX_W);
    localparam logic [WCNT_W-1:0] ONE_C = WCNT_W'(1);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t            state;
        state_t            state_nxt;
        logic [WCNT_W-1:0] cnt;
        logic [WCNT_W-1:0] cnt_nxt;
        logic [WCNT_W-1:0] width_q;
        logic              act;
        logic              accept_nxt;
        logic              reject_nxt;
        logic              pulse_q;
        logic              reject_q;

        assign act = (POLARITY != 0) ? data_in[g] : ~data_in[g];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= S_IDLE;
                cnt      <= '0;
                pulse_q  <= 1'b0;
                reject_q <= 1'b0;
                width_q  <= '0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                pulse_q  <= accept_nxt;
                reject_q <= reject_nxt;
                if (accept_nxt) begin
                    width_q <= cnt;
                end
            end
        end

        // The trailing idle sample lands in ARMED so it doubles as the next pulse's leading idle.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            if (!en) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!act) state_nxt = S_ARMED;
                    end
                    S_ARMED: begin
                        if (act) begin
                            state_nxt = S_ACTIVE;
                            cnt_nxt   = ONE_C;
                        end
                    end
                    S_ACTIVE: begin
                        if (act) begin
                            if (cnt == MAX_C) state_nxt = S_TOOLONG;
                            else              cnt_nxt   = cnt + ONE_C;
                        end else begin
                            state_nxt = S_ARMED;
                            cnt_nxt   = '0;
                        end
                    end
                    S_TOOLONG: begin
                        if (!act) begin
                            state_nxt = S_ARMED;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        always_comb begin
            accept_nxt = 1'b0;
            reject_nxt = 1'b0;
            if (en && state == S_ACTIVE) begin
                if (act) begin
                    reject_nxt = (cnt == MAX_C);
                end else begin
                    accept_nxt = (cnt >= MIN_C);
                    reject_nxt = (cnt < MIN_C);
                end
            end
        end

        assign pulse_out[g]                     = pulse_q;
        assign reject[g]                        = reject_q;
        assign pulse_width[g*WCNT_W +: WCNT_W]  = width_q;

`ifdef PULSE_DET_CNT_EN
        logic [7:0] evt_q;

        // Counts alongside the pulse_out register so a clear in that cycle wins over the increment.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                evt_q <= 8'd0;
            end else if (cnt_clr) begin
                evt_q <= 8'd0;
            end else if (accept_nxt && evt_q != 8'hFF) begin
                evt_q <= evt_q + 8'd1;
            end
        end

        assign evt_cnt[g*8 +: 8] = evt_q;
`endif
    end

endmodule

// File: tb/tb_pulse_width_detect_mc.sv
// tb/tb_pulse_width_detect_mc.sv - directed table-driven bench for pulse_width_detect_mc
module tb_pulse_width_detect_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] d_def;
    logic [3:0] po_def, rj_def, pw_def;
    logic [0:0] d_win, po_win, rj_win;
    logic [2:0] pw_win;
    logic [3:0] d_pol, po_pol, rj_pol, pw_pol;
`ifdef PULSE_DET_CNT_EN
    logic        cnt_clr;
    logic [31:0] ec_def, ec_pol;
    logic [7:0]  ec_win;
`endif

    always #5 clk = ~clk;

    pulse_width_detect_mc u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(d_def),
        .pulse_out(po_def), .pulse_width(pw_def), .reject(rj_def)
`ifdef PULSE_DET_CNT_EN
        , .cnt_clr(cnt_clr), .evt_cnt(ec_def)
`endif
    );

    pulse_width_detect_mc #(.CH(1), .MIN_W(2), .MAX_W(4)) u_win (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(d_win),
        .pulse_out(po_win), .pulse_width(pw_win), .reject(rj_win)
`ifdef PULSE_DET_CNT_EN
        , .cnt_clr(cnt_clr), .evt_cnt(ec_win)
`endif
    );

    pulse_width_detect_mc #(.POLARITY(0)) u_pol (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(d_pol),
        .pulse_out(po_pol), .pulse_width(pw_pol), .reject(rj_pol)
`ifdef PULSE_DET_CNT_EN
        , .cnt_clr(cnt_clr), .evt_cnt(ec_pol)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ch0 and ch2 carry the vector, ch1 is stuck active, ch3 is stuck idle
    task automatic set_def(input logic v);
        d_def = {1'b0, v, 1'b1, v};
    endtask

    typedef struct {
        logic en;
        logic d;
        logic p;
        logic r;
        logic w;
    } vec_t;

    typedef struct {
        int         w;
        logic       acc;
        logic       rej_short;
        logic       rej_long;
        logic [2:0] width;
    } wvec_t;

    function automatic vec_t mk(input logic e, input logic d, input logic p, input logic r, input logic w);
        vec_t v;
        v.en = e; v.d = d; v.p = p; v.r = r; v.w = w;
        return v;
    endfunction

    function automatic wvec_t mkw(input int w, input logic a, input logic rs, input logic rl, input logic [2:0] wd);
        wvec_t v;
        v.w = w; v.acc = a; v.rej_short = rs; v.rej_long = rl; v.width = wd;
        return v;
    endfunction

    vec_t  vt[17];
    wvec_t wt[6];

    initial begin
        vt[0]  = mk(1, 0, 0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0);
        vt[2]  = mk(1, 0, 1, 0, 1);
        vt[3]  = mk(1, 1, 0, 0, 1);
        vt[4]  = mk(1, 0, 1, 0, 1);
        vt[5]  = mk(1, 1, 0, 0, 1);
        vt[6]  = mk(1, 1, 0, 1, 1);
        vt[7]  = mk(1, 0, 0, 0, 1);
        vt[8]  = mk(1, 1, 0, 0, 1);
        vt[9]  = mk(1, 1, 0, 1, 1);
        vt[10] = mk(1, 1, 0, 0, 1);
        vt[11] = mk(1, 0, 0, 0, 1);
        vt[12] = mk(1, 1, 0, 0, 1);
        vt[13] = mk(0, 0, 0, 0, 1);
        vt[14] = mk(1, 0, 0, 0, 1);
        vt[15] = mk(1, 1, 0, 0, 1);
        vt[16] = mk(1, 0, 1, 0, 1);

        wt[0] = mkw(1,  0, 1, 0, 3'd0);
        wt[1] = mkw(2,  1, 0, 0, 3'd2);
        wt[2] = mkw(4,  1, 0, 0, 3'd4);
        wt[3] = mkw(5,  0, 0, 1, 3'd4);
        wt[4] = mkw(3,  1, 0, 0, 3'd3);
        wt[5] = mkw(14, 0, 0, 1, 3'd3);

        rst_n = 1'b0;
        en    = 1'b1;
        set_def(1'b1);
        d_win = 1'b0;
        d_pol = 4'h0;
`ifdef PULSE_DET_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (3) step();
        chk("rst_def_strobes", {po_def, rj_def}, 0);
        chk("rst_def_width", pw_def, 0);
        chk("rst_win_all", {po_win, rj_win, pw_win}, 0);
        chk("rst_pol_all", {po_pol, rj_pol, pw_pol}, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) begin
            en = vt[k].en;
            set_def(vt[k].d);
            step();
            chk($sformatf("vec%0d_pulse", k), po_def, {1'b0, vt[k].p, 1'b0, vt[k].p});
            chk($sformatf("vec%0d_reject", k), rj_def, {1'b0, vt[k].r, 1'b0, vt[k].r});
            chk($sformatf("vec%0d_width", k), pw_def, {1'b0, vt[k].w, 1'b0, vt[k].w});
        end
        en = 1'b1;

        // active level held from reset: no leading idle sample, so nothing may fire
        chk("pol_held_active", {po_pol, rj_pol}, 0);
        d_pol = 4'hF; step();
        chk("pol_idle", {po_pol, rj_pol}, 0);
        d_pol = 4'h0; step();
        chk("pol_active", {po_pol, rj_pol}, 0);
        d_pol = 4'hF; step();
        chk("pol_all_pulse", po_pol, 4'hF);
        chk("pol_all_reject", rj_pol, 4'h0);
        chk("pol_all_width", pw_pol, 4'hF);
        step();
        chk("pol_single_cycle", po_pol, 4'h0);

        d_win = 1'b0; step();
        for (int i = 0; i < 6; i++) begin
            for (int j = 1; j <= wt[i].w; j++) begin
                d_win = 1'b1; step();
                chk($sformatf("win%0d_act%0d_rej", wt[i].w, j), rj_win, (wt[i].rej_long && j == 5));
                chk($sformatf("win%0d_act%0d_pulse", wt[i].w, j), po_win, 0);
            end
            d_win = 1'b0; step();
            chk($sformatf("win%0d_pulse", wt[i].w), po_win, wt[i].acc);
            chk($sformatf("win%0d_reject", wt[i].w), rj_win, wt[i].rej_short);
            chk($sformatf("win%0d_width", wt[i].w), pw_win, wt[i].width);
        end

        d_win = 1'b1; step();
        en = 1'b0; step();
        en = 1'b1; step();
        d_win = 1'b0; step();
        chk("en_drop_strobes", {po_win, rj_win}, 0);
        chk("en_drop_width", pw_win, 3'd3);

        set_def(1'b1); step();
        set_def(1'b0); step();
        chk("pre_rst_pulse", po_def, 4'b0101);
        set_def(1'b1); step();
        chk("pre_rst_width", pw_def, 4'b0101);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_width", pw_def, 0);
        chk("async_rst_strobes", {po_def, rj_def}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_def(1'b0); step();
        chk("post_rst_no_strobe", {po_def, rj_def}, 0);
        set_def(1'b1); step();
        set_def(1'b0); step();
        chk("post_rst_pulse", po_def, 4'b0101);

`ifdef PULSE_DET_CNT_EN
        for (int n = 0; n < 300; n++) begin
            set_def(1'b1); step();
            set_def(1'b0); step();
        end
        chk("evt_sat_ch0", ec_def[7:0], 8'd255);
        chk("evt_sat_ch2", ec_def[23:16], 8'd255);
        chk("evt_ch1_zero", ec_def[15:8], 8'd0);
        set_def(1'b1); step();
        set_def(1'b0); cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        chk("clr_pulse", po_def[0], 1'b1);
        chk("clr_evt_ch0", ec_def[7:0], 8'd0);
        set_def(1'b1); step();
        set_def(1'b0); step();
        chk("evt_after_clr", ec_def[7:0], 8'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
